// File: rtl/reaction_timer_core_if.sv
// Button inputs and measurement/status outputs of the reaction timer core.
// slave is the core's view, master the driver/consumer's view.
interface reaction_timer_core_if;
   logic        start;
   logic        stop;
   logic [19:0] hex_number;
   logic        led_on;
   logic        busy;
   logic        false_start;
   logic        done;

   modport slave  (input  start, stop,
                   output hex_number, led_on, busy, false_start, done);
   modport master (output start, stop,
                   input  hex_number, led_on, busy, false_start, done);
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction-time engine: random wait, stimulus LED, then a millisecond count
// until stop. Result is held on hex_number for the BCD/7-segment path.
module reaction_timer_core #(
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned MAX_COUNT    = 999999,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   reaction_timer_core_if.slave  bus
);

   localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned MSW = 12;
   localparam int unsigned HW  = 20;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HEX_MAX    = HW'(MAX_COUNT);
   localparam logic [MSW-1:0] DELAY_MIN = MSW'(MIN_DELAY_MS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_TIMING,
      S_DONE,
      S_FALSE
   } state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic           r_start_q;
   logic           r_stop_q;
   logic           w_start_rise;
   logic           w_stop_rise;
   logic [15:0]    r_lfsr;
   logic           w_lfsr_fb;
   logic [PW-1:0]  r_presc;
   logic [PW-1:0]  w_presc_next;
   logic           w_tick;
   logic [MSW-1:0] r_ms;
   logic [MSW-1:0] r_delay;
   logic           w_delay_hit;
   logic [HW-1:0]  r_hex;
   logic           w_led_on;
   logic           w_busy;
   logic           w_false_start;
   logic           w_done;
   logic           r_led_on;
   logic           r_busy;
   logic           r_false_start;
   logic           r_done;

   assign w_start_rise = bus.start & ~r_start_q;
   assign w_stop_rise  = bus.stop  & ~r_stop_q;
   assign w_lfsr_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign w_tick       = (r_presc == PRESC_LAST);
   assign w_presc_next = w_tick ? '0 : r_presc + PW'(1);
   assign w_delay_hit  = (r_ms == r_delay);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; stop takes priority over start except when idle
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_FALSE: begin
            if (w_start_rise) w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_stop_rise)      w_state_next = S_FALSE;
            else if (w_delay_hit) w_state_next = S_TIMING;
         end
         S_TIMING: begin
            if (w_stop_rise) w_state_next = S_DONE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Status decode from the next state so the registered flags track r_state
   always_comb begin
      w_led_on      = 1'b0;
      w_busy        = 1'b0;
      w_false_start = 1'b0;
      w_done        = 1'b0;
      case (w_state_next)
         S_WAIT:   w_busy        = 1'b1;
         S_TIMING: begin
            w_busy   = 1'b1;
            w_led_on = 1'b1;
         end
         S_DONE:   w_done        = 1'b1;
         S_FALSE:  w_false_start = 1'b1;
         default:  ;
      endcase
   end

   // Registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_led_on      <= 1'b0;
         r_busy        <= 1'b0;
         r_false_start <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_led_on      <= w_led_on;
         r_busy        <= w_busy;
         r_false_start <= w_false_start;
         r_done        <= w_done;
      end
   end

   // Edge detect, free-running LFSR, prescaler, ms counter and result
   always_ff @(posedge clk) begin
      if (reset) begin
         r_start_q <= 1'b0;
         r_stop_q  <= 1'b0;
         r_lfsr    <= LFSR_SEED;
         r_presc   <= '0;
         r_ms      <= '0;
         r_delay   <= '0;
         r_hex     <= '0;
      end else begin
         r_start_q <= bus.start;
         r_stop_q  <= bus.stop;
         r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
         case (r_state)
            S_IDLE, S_DONE, S_FALSE: begin
               if (w_start_rise) begin
                  r_delay <= DELAY_MIN + MSW'(r_lfsr[10:0]);
                  r_presc <= '0;
                  r_ms    <= '0;
                  r_hex   <= '0;
               end
            end
            S_WAIT: begin
               if (!w_stop_rise) begin
                  if (w_delay_hit) begin
                     r_presc <= '0;
                     r_hex   <= '0;
                  end else begin
                     r_presc <= w_presc_next;
                     if (w_tick) r_ms <= r_ms + MSW'(1);
                  end
               end
            end
            S_TIMING: begin
               // A tick landing on the stop edge is deliberately dropped
               if (!w_stop_rise) begin
                  r_presc <= w_presc_next;
                  if (w_tick && (r_hex < HEX_MAX)) r_hex <= r_hex + HW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.hex_number  = r_hex;
   assign bus.led_on      = r_led_on;
   assign bus.busy        = r_busy;
   assign bus.false_start = r_false_start;
   assign bus.done        = r_done;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench: dut_a (4-cycle tick, short minimum wait) covers timing,
// false start and priorities; dut_b (1-cycle tick, MAX_COUNT=20) covers saturation and delay range.
module tb_reaction_timer_core;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   reaction_timer_core_if ifa ();
   reaction_timer_core_if ifb ();

   reaction_timer_core #(.TICK_DIV(4), .MIN_DELAY_MS(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   reaction_timer_core #(.TICK_DIV(1), .MAX_COUNT(20)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All tasks begin and end just after a falling edge
   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_start_a();
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
   endtask

   task automatic pulse_stop_a();
      ifa.stop = 1'b1;
      @(negedge clk);
      ifa.stop = 1'b0;
   endtask

   task automatic wait_led_a(output bit ok);
      int n;
      n = 0;
      while (ifa.led_on !== 1'b1 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      ok = (ifa.led_on === 1'b1);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL wait_led_a: led_on=%b after %0d cycles, required 1", ifa.led_on, n);
      end
   endtask

   // Returns the programmed delay in ms, derived from cycles start->led (tick=1 cycle)
   task automatic run_b_measure(output int delay, output bit ok);
      int n;
      ifb.start = 1'b1;
      @(negedge clk);
      ifb.start = 1'b0;
      n = 1;
      while (ifb.led_on !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      ok    = (ifb.led_on === 1'b1);
      delay = n - 2;
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (10) @(negedge clk);
      total++;
      if (ifa.hex_number !== 20'd0) begin
         bad++; $display("FAIL reset_hex: got %0d required 0", ifa.hex_number);
      end
      total++;
      if (ifa.led_on !== 1'b0) begin
         bad++; $display("FAIL reset_led: got %b required 0", ifa.led_on);
      end
      total++;
      if (ifa.busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy: got %b required 0", ifa.busy);
      end
      total++;
      if (ifa.false_start !== 1'b0) begin
         bad++; $display("FAIL reset_false_start: got %b required 0", ifa.false_start);
      end
      total++;
      if (ifa.done !== 1'b0) begin
         bad++; $display("FAIL reset_done: got %b required 0", ifa.done);
      end
      total++;
      if (dut_a.r_lfsr === 16'd0 || $isunknown(dut_a.r_lfsr)) begin
         bad++; $display("FAIL reset_lfsr: got %h required non-zero", dut_a.r_lfsr);
      end
      total++;
      if (ifb.hex_number !== 20'd0 || ifb.busy !== 1'b0) begin
         bad++; $display("FAIL reset_b: hex=%0d busy=%b required 0/0", ifb.hex_number, ifb.busy);
      end
   endtask

   task automatic test_measure();
      bit ok;
      bit stable;
      apply_reset();
      pulse_start_a();
      total++;
      if (ifa.busy !== 1'b1 || ifa.led_on !== 1'b0) begin
         bad++; $display("FAIL wait_entry: busy=%b led=%b required 1/0", ifa.busy, ifa.led_on);
      end
      wait_led_a(ok);
      repeat (40) @(negedge clk);
      pulse_stop_a();
      total++;
      if (ifa.done !== 1'b1 || ifa.led_on !== 1'b0 || ifa.busy !== 1'b0) begin
         bad++; $display("FAIL measure_flags: done=%b led=%b busy=%b required 1/0/0", ifa.done, ifa.led_on, ifa.busy);
      end
      total++;
      if (ifa.hex_number !== 20'd10) begin
         bad++; $display("FAIL measure_hex: got %0d required 10", ifa.hex_number);
      end
      stable = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (ifa.hex_number !== 20'd10 || ifa.done !== 1'b1) stable = 1'b0;
      end
      total++;
      if (!stable) begin
         bad++; $display("FAIL measure_hold: hex=%0d done=%b required 10/1 for 100 cycles", ifa.hex_number, ifa.done);
      end
      pulse_start_a();
      total++;
      if (ifa.hex_number !== 20'd0 || ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
         bad++; $display("FAIL restart_from_done: hex=%0d busy=%b done=%b required 0/1/0", ifa.hex_number, ifa.busy, ifa.done);
      end
   endtask

   task automatic test_false_start();
      bit led_seen;
      apply_reset();
      pulse_start_a();
      repeat (5) @(negedge clk);
      pulse_stop_a();
      total++;
      if (ifa.false_start !== 1'b1 || ifa.busy !== 1'b0) begin
         bad++; $display("FAIL false_start_flag: fs=%b busy=%b required 1/0", ifa.false_start, ifa.busy);
      end
      led_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ifa.led_on !== 1'b0 || ifa.hex_number !== 20'd0) led_seen = 1'b1;
      end
      total++;
      if (led_seen) begin
         bad++; $display("FAIL false_start_hold: led=%b hex=%0d required 0/0", ifa.led_on, ifa.hex_number);
      end
      pulse_start_a();
      total++;
      if (ifa.busy !== 1'b1 || ifa.false_start !== 1'b0 || ifa.led_on !== 1'b0) begin
         bad++; $display("FAIL rearm_after_false: busy=%b fs=%b led=%b required 1/0/0", ifa.busy, ifa.false_start, ifa.led_on);
      end
      repeat (3) @(negedge clk);
      ifa.start = 1'b1;
      ifa.stop  = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      ifa.stop  = 1'b0;
      total++;
      if (ifa.false_start !== 1'b1 || ifa.busy !== 1'b0) begin
         bad++; $display("FAIL wait_both_edges: fs=%b busy=%b required 1/0", ifa.false_start, ifa.busy);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      apply_reset();
      ifa.start = 1'b1;
      ifa.stop  = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      ifa.stop  = 1'b0;
      total++;
      if (ifa.busy !== 1'b1 || ifa.false_start !== 1'b0) begin
         bad++; $display("FAIL idle_both_edges: busy=%b fs=%b required 1/0", ifa.busy, ifa.false_start);
      end
      wait_led_a(ok);
      for (int c = 0; c < 40; c++) begin
         ifa.start = (c == 5 || c == 15 || c == 25);
         @(negedge clk);
      end
      total++;
      if (ifa.led_on !== 1'b1 || ifa.hex_number !== 20'd10) begin
         bad++; $display("FAIL timing_ignore_start: led=%b hex=%0d required 1/10", ifa.led_on, ifa.hex_number);
      end
      ifa.start = 1'b1;
      ifa.stop  = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      ifa.stop  = 1'b0;
      total++;
      if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || ifa.hex_number !== 20'd10) begin
         bad++; $display("FAIL timing_both_edges: done=%b busy=%b hex=%0d required 1/0/10", ifa.done, ifa.busy, ifa.hex_number);
      end
   endtask

   task automatic test_reset_timing();
      bit ok;
      apply_reset();
      pulse_start_a();
      wait_led_a(ok);
      repeat (28) @(negedge clk);
      total++;
      if (ifa.hex_number !== 20'd7 || ifa.led_on !== 1'b1) begin
         bad++; $display("FAIL pre_reset_count: hex=%0d led=%b required 7/1", ifa.hex_number, ifa.led_on);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (ifa.hex_number !== 20'd0 || ifa.led_on !== 1'b0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
         bad++; $display("FAIL mid_reset: hex=%0d led=%b busy=%b done=%b required 0/0/0/0", ifa.hex_number, ifa.led_on, ifa.busy, ifa.done);
      end
   endtask

   task automatic test_saturation();
      int delay;
      bit ok;
      apply_reset();
      run_b_measure(delay, ok);
      total++;
      if (!ok || delay < 1000 || delay > 3047) begin
         bad++; $display("FAIL sat_delay: delay=%0d ok=%b required 1000..3047", delay, ok);
      end
      repeat (50) @(negedge clk);
      total++;
      if (ifb.hex_number !== 20'd20 || ifb.led_on !== 1'b1 || ifb.busy !== 1'b1) begin
         bad++; $display("FAIL saturate: hex=%0d led=%b busy=%b required 20/1/1", ifb.hex_number, ifb.led_on, ifb.busy);
      end
      ifb.stop = 1'b1;
      @(negedge clk);
      ifb.stop = 1'b0;
      total++;
      if (ifb.done !== 1'b1 || ifb.led_on !== 1'b0 || ifb.hex_number !== 20'd20) begin
         bad++; $display("FAIL sat_stop: done=%b led=%b hex=%0d required 1/0/20", ifb.done, ifb.led_on, ifb.hex_number);
      end
   endtask

   task automatic test_delay_range();
      int  delays [4];
      bit  ok;
      bit  all_same;
      for (int r = 0; r < 4; r++) begin
         repeat (r + 3) @(negedge clk);
         run_b_measure(delays[r], ok);
         total++;
         if (!ok || delays[r] < 1000 || delays[r] > 3047) begin
            bad++; $display("FAIL delay_range run %0d: delay=%0d ok=%b required 1000..3047", r, delays[r], ok);
         end
         ifb.stop = 1'b1;
         @(negedge clk);
         ifb.stop = 1'b0;
      end
      all_same = (delays[0] == delays[1]) && (delays[1] == delays[2]) && (delays[2] == delays[3]);
      total++;
      if (all_same) begin
         bad++; $display("FAIL delay_varies: all four delays=%0d required not all equal", delays[0]);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      ifa.start = 1'b0;
      ifa.stop  = 1'b0;
      ifb.start = 1'b0;
      ifb.stop  = 1'b0;
      @(negedge clk);
      test_reset();
      test_measure();
      test_false_start();
      test_simultaneous();
      test_reset_timing();
      test_saturation();
      test_delay_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
- Reaction-time measurement engine that produces the 20-bit millisecond count consumed by the binary-to-BCD converter and 7-segment display path.
- On a start request it waits a pseudo-random delay, then lights the stimulus LED and counts milliseconds until the user presses stop.
- Holds the result on hex_number until the next start.
- Detects false starts (stop pressed before the LED lights).

Parameters:
- TICK_DIV, 50000, clk cycles per millisecond tick (50 MHz board clock); benches override with a small value.
- MAX_COUNT, 999999, saturation value of hex_number; the largest value six BCD digits can show.
- MIN_DELAY_MS, 1000, minimum random wait in ms.
- LFSR_SEED, 16'hACE1, reset value of the random generator; must be non-zero.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  start button level, already synchronised and debounced; rising edge is used
- stop  input  1  reaction button level, already synchronised and debounced; rising edge is used
- hex_number  output  20  measured time in ms, binary, feeds the BCD converter
- led_on  output  1  stimulus LED, high only in TIMING
- busy  output  1  high in WAIT and TIMING
- false_start  output  1  high in FALSE_START
- done  output  1  high in DONE

Behaviour:
- Reset, sampled on a clk rising edge:
  - state=IDLE; hex_number=0; led_on=0; busy=0; false_start=0; done=0.
  - Prescaler=0; edge-detect registers=0; lfsr=LFSR_SEED.
- Edge detect: start_rise = start & ~start_q, likewise stop_rise; the _q registers are updated every cycle.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Free-running every cycle, including IDLE; never reaches zero.
- State IDLE, DONE and FALSE_START:
  - start_rise latches delay_ms = MIN_DELAY_MS + lfsr[10:0], giving 1000..3047 ms.
  - On the same edge: clear prescaler and ms counter, set hex_number=0, go to WAIT.
  - stop_rise alone is ignored.
- State WAIT:
  - Prescaler counts 0..TICK_DIV-1; each wrap is one tick and increments the ms counter.
  - When the ms counter reaches delay_ms: clear prescaler and hex_number, go to TIMING. led_on rises on the following cycle.
  - stop_rise in WAIT goes to FALSE_START; hex_number stays 0.
  - start_rise is ignored.
- State TIMING:
  - led_on=1; hex_number increments by 1 on each tick.
  - hex_number saturates at MAX_COUNT and holds there; the state does not change on saturation.
  - stop_rise on cycle N: state=DONE and led_on=0 at N+1, hex_number frozen at its cycle-N value.
  - A tick coinciding with stop_rise is not counted.
  - start_rise is ignored.
- Simultaneous start_rise and stop_rise:
  - In IDLE, DONE or FALSE_START, start wins.
  - In WAIT, stop wins (false start).
  - In TIMING, stop wins.
- Status outputs (led_on, busy, false_start, done) are registered and decoded from the state register; no combinational paths from inputs.
- Reset asserted mid-operation (any state) returns to IDLE on that edge; hex_number clears to 0.
- Width rules:
  - Prescaler sized to clog2(TICK_DIV).
  - ms counter is 12 bits.
  - hex_number is 20 bits; 999999 < 2^20, so no overflow.
- Measurement resolution is 1 ms, with 0..1 ms quantisation.

Test Plan:
- Reset, then 10 idle cycles -> all outputs 0, hex_number=0, lfsr not stuck at 0.
- TICK_DIV=4; start pulse; stop pulse 40 cycles after led_on rises -> done=1, led_on=0, hex_number=10, value stable for 100 cycles.
- TICK_DIV=4; start; stop during WAIT -> false_start=1, hex_number=0, led_on never asserts; a new start then re-enters WAIT.
- TICK_DIV=1, MAX_COUNT=20; start, no stop -> hex_number climbs to 20 and holds with led_on=1; later stop -> done, hex_number=20.
- Start and stop rising on the same cycle from IDLE -> WAIT entered, not FALSE_START. In TIMING, extra start pulses -> no effect on count.
- Reset asserted during TIMING with hex_number=7 -> next cycle state IDLE, hex_number=0, led_on=0. Repeated runs -> delay_ms always within 1000..3047 ms.
